bram_dp_rr_arbiter: RTL and testbench
=====================================

// Module: bram_dp_rr_arbiter
// PURPOSE
//  Shares one dual-port 4096x4 BRAM (two ports, common clock, 1-cycle read) among NREQ requesters.
//  Each cycle it grants up to two requests round-robin, one per BRAM port.
//  It blocks same-address hazards between the two ports and returns read data to the requester that issued it.
//  It sits between accelerator-side memory clients and the BRAM wrapper.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  AW      12  address width
//  DW      4   data width
//  RD_LAT  1   BRAM read latency in cycles (address sampled at edge t -> Q valid after edge t+RD_LAT-1)
// PORTS
//  CLK        in   1         single clock, rising edge
//  RST        in   1         asynchronous reset, active-high
//  req_valid  in   NREQ      request present, per requester
//  req_ready  out  NREQ      request accepted this cycle (valid&ready = handshake)
//  req_we     in   NREQ      1=write, 0=read
//  req_addr   in   NREQ*AW   address, requester i at [i*AW +: AW]
//  req_wdata  in   NREQ*DW   write data
//  rsp_valid  out  NREQ      read data valid for requester i
//  rsp_rdata  out  NREQ*DW   read data (valid only when rsp_valid[i])
//  A0,A1      out  AW        BRAM port 0/1 address
//  D0,D1      out  DW        BRAM port 0/1 write data
//  WE0,WE1    out  1         BRAM port 0/1 write enable
//  CE0,CE1    out  1         BRAM port 0/1 enable
//  Q0,Q1      in   DW        BRAM port 0/1 read data
// BEHAVIOUR
//  Reset: while RST=1 all outputs are 0 (req_ready, rsp_valid, CE*, WE*, A*, D*); rr_ptr=0; read pipeline cleared.
//  Deassertion: first grant possible in the first cycle with RST=0.
//  Grant, combinational within the cycle:
//   - scan requesters from rr_ptr upward, modulo NREQ
//   - first valid requester -> port 0
//   - next valid requester -> port 1, unless it conflicts with the port-0 grant
//   - conflict = same req_addr and at least one of the two is a write; conflicting requester waits, scan continues
//   - two reads to the same address are both granted
//  Port drive: granted request drives A/D/WE with CE=1 in the same cycle; the BRAM samples at the next edge.
//   Ungranted port: CE=0, WE=0, A=0, D=0.
//  req_ready[i]=1 only for granted requesters. A requester never sees ready without valid.
//  rr_ptr update: at each edge with >=1 grant, rr_ptr <= (index of last granted requester + 1) mod NREQ; otherwise held.
//  Read return:
//   - per-port shift pipeline of {valid, requester id}, depth RD_LAT
//   - rsp_valid[id]=1 exactly RD_LAT cycles after the handshake edge; rsp_rdata[id] = Q of that port
//   - rsp_valid is registered; rsp_rdata is muxed from Q0/Q1 by the pipeline id
//   - writes produce no response
//  Ordering: at most 2 handshakes per cycle; per requester, responses return in issue order.
//   One requester holds at most one grant per cycle.
//  Full-rate: back-to-back reads from one requester get one response per cycle; no bubbles.
//  Reset mid-operation: in-flight reads are discarded; no rsp_valid after RST rises, including for pending pipeline entries.
//  Idle (no req_valid): CE0=CE1=0; rr_ptr unchanged.
//  Single requester: always takes port 0; port 1 idle.
// TESTING
//  1 Reset: RST=1 with all req_valid=1 -> req_ready=0, CE0=CE1=0. Release RST -> cycle 1 grants req0->port0, req1->port1.
//  2 Write then read: req2 writes addr 0x0A5 data 0x9; next cycle req2 reads 0x0A5 -> rsp_valid[2]=1 one cycle later, rsp_rdata=0x9.
//  3 Fairness: all 4 requesters continuously valid reading -> grant pairs {0,1},{2,3},{0,1}..., each ready once per 2 cycles.
//  4 Hazard: req0 writes 0x123, req1 reads 0x123 in the same cycle -> only req0 granted; req1 granted next cycle and reads the new data.
//  5 Dual read, same address: req1 and req3 both read 0x7FF -> both granted; both rsp_valid one cycle later with equal data.
//  6 Reset mid-flight: assert RST in the cycle after a read handshake -> rsp_valid stays 0; after release, no stale response appears.

Source files
------------

// File: rtl/bram_dp_rr_arbiter.sv
// Round-robin arbiter sharing a dual-port BRAM among NREQ requesters.
// Grants up to two hazard-free requests per cycle and routes read data back.
module bram_dp_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int AW     = 12,
    parameter int DW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [NREQ*DW-1:0] rsp_rdata,
    output logic [AW-1:0]     A0,
    output logic [AW-1:0]     A1,
    output logic [DW-1:0]     D0,
    output logic [DW-1:0]     D1,
    output logic              WE0,
    output logic              WE1,
    output logic              CE0,
    output logic              CE1,
    input  logic [DW-1:0]     Q0,
    input  logic [DW-1:0]     Q1
);
    localparam int IW = $clog2(NREQ);
    localparam int L  = RD_LAT - 1;
    localparam logic [IW:0] NR = (IW+1)'(NREQ);

    logic [IW-1:0] r_ptr;
    logic [RD_LAT-1:0] r_v0, r_v1;
    logic [RD_LAT-1:0][IW-1:0] r_id0, r_id1;

    logic [AW-1:0] w_addr  [NREQ];
    logic [DW-1:0] w_wdata [NREQ];
    logic          w_g0_v, w_g1_v;
    logic [IW-1:0] w_g0, w_g1, w_last, w_nxt;
    logic [IW:0]   w_inc;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_addr[i]  = req_addr[i*AW +: AW];
            w_wdata[i] = req_wdata[i*DW +: DW];
        end
    end

    // Scan from r_ptr; port 1 skips requesters that collide with port 0
    always_comb begin : grant
        logic [IW:0]   v_sum;
        logic [IW-1:0] v_idx;
        w_g0_v = 1'b0;
        w_g1_v = 1'b0;
        w_g0   = '0;
        w_g1   = '0;
        v_sum  = '0;
        v_idx  = '0;
        if (!RST) begin
            for (int k = 0; k < NREQ; k++) begin
                v_sum = {1'b0, r_ptr} + (IW+1)'(k);
                if (v_sum >= NR) v_sum = v_sum - NR;
                v_idx = v_sum[IW-1:0];
                if (req_valid[v_idx]) begin
                    if (!w_g0_v) begin
                        w_g0_v = 1'b1;
                        w_g0   = v_idx;
                    end else if (!w_g1_v &&
                                 !((w_addr[v_idx] == w_addr[w_g0]) &&
                                   (req_we[v_idx] || req_we[w_g0]))) begin
                        w_g1_v = 1'b1;
                        w_g1   = v_idx;
                    end
                end
            end
        end
    end

    assign w_last = w_g1_v ? w_g1 : w_g0;
    assign w_inc  = {1'b0, w_last} + (IW+1)'(1);
    assign w_nxt  = (w_inc == NR) ? '0 : w_inc[IW-1:0];

    assign CE0 = w_g0_v;
    assign WE0 = w_g0_v & req_we[w_g0];
    assign A0  = w_g0_v ? w_addr[w_g0]  : '0;
    assign D0  = w_g0_v ? w_wdata[w_g0] : '0;
    assign CE1 = w_g1_v;
    assign WE1 = w_g1_v & req_we[w_g1];
    assign A1  = w_g1_v ? w_addr[w_g1]  : '0;
    assign D1  = w_g1_v ? w_wdata[w_g1] : '0;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (w_g0_v && (w_g0 == IW'(i))) ||
                           (w_g1_v && (w_g1 == IW'(i)));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr <= '0;
            r_v0  <= '0;
            r_v1  <= '0;
            r_id0 <= '0;
            r_id1 <= '0;
        end else begin
            if (w_g0_v) r_ptr <= w_nxt;
            for (int j = RD_LAT - 1; j > 0; j--) begin
                r_v0[j]  <= r_v0[j-1];
                r_v1[j]  <= r_v1[j-1];
                r_id0[j] <= r_id0[j-1];
                r_id1[j] <= r_id1[j-1];
            end
            r_v0[0]  <= w_g0_v & ~req_we[w_g0];
            r_v1[0]  <= w_g1_v & ~req_we[w_g1];
            r_id0[0] <= w_g0;
            r_id1[0] <= w_g1;
        end
    end

    // Response routing: the two ports never carry the same requester at once
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = 1'b0;
            rsp_rdata[i*DW +: DW] = '0;
            if (r_v0[L] && (r_id0[L] == IW'(i))) begin
                rsp_valid[i] = 1'b1;
                rsp_rdata[i*DW +: DW] = Q0;
            end else if (r_v1[L] && (r_id1[L] == IW'(i))) begin
                rsp_valid[i] = 1'b1;
                rsp_rdata[i*DW +: DW] = Q1;
            end
        end
    end
endmodule

// File: tb/tb_bram_dp_rr_arbiter.sv
// Bench for bram_dp_rr_arbiter: directed scenarios plus random traffic
// against a behavioural grant/memory model and a BRAM behavioural model.
module tb_bram_dp_rr_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 12;
    localparam int DW   = 4;

    logic               CLK;
    logic               RST;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_rdata;
    logic [AW-1:0]      A0, A1;
    logic [DW-1:0]      D0, D1;
    logic               WE0, WE1, CE0, CE1;
    logic [DW-1:0]      Q0, Q1;

    bram_dp_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .A0(A0), .A1(A1), .D0(D0), .D1(D1),
        .WE0(WE0), .WE1(WE1), .CE0(CE0), .CE1(CE1),
        .Q0(Q0), .Q1(Q1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // BRAM behavioural model, one-cycle read
    logic [DW-1:0] bram [4096];
    always @(posedge CLK) begin
        if (CE0) begin
            if (WE0) bram[A0] <= D0;
            else     Q0 <= bram[A0];
        end
        if (CE1) begin
            if (WE1) bram[A1] <= D1;
            else     Q1 <= bram[A1];
        end
    end

    int checks = 0;
    int errors = 0;

    int            m_ptr;
    logic [DW-1:0] m_mem [4096];
    logic [NREQ-1:0] m_pv;
    logic [DW-1:0] m_pd [NREQ];
    int            rdy_cnt [NREQ];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return req_wdata[i*DW +: DW];
    endfunction

    // Reference grant rule: walk requesters in round-robin order from m_ptr
    task automatic model(output int g0, output int g1);
        int order [$];
        g0 = -1;
        g1 = -1;
        if (RST) return;
        for (int k = 0; k < NREQ; k++) order.push_back((m_ptr + k) % NREQ);
        foreach (order[n]) begin
            int r;
            r = order[n];
            if (req_valid[r]) begin
                if (g0 < 0) g0 = r;
                else if (g1 < 0) begin
                    if (!(addr_of(r) == addr_of(g0) && (req_we[r] || req_we[g0])))
                        g1 = r;
                end
            end
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit we,
                           input int addr, input int data);
        req_valid[i] = v;
        req_we[i]    = we;
        req_addr[i*AW +: AW]  = AW'(addr);
        req_wdata[i*DW +: DW] = DW'(data);
    endtask

    task automatic clr();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // Called just after a falling edge; returns at the next falling edge
    task automatic tick();
        int g0, g1;
        logic [NREQ-1:0] er;
        logic [AW+DW+1:0] e0, e1;
        #1;
        if (RST) m_pv = '0;
        model(g0, g1);
        er = '0;
        e0 = '0;
        e1 = '0;
        if (g0 >= 0) begin
            er[g0] = 1'b1;
            e0 = {1'b1, req_we[g0], addr_of(g0), data_of(g0)};
        end
        if (g1 >= 0) begin
            er[g1] = 1'b1;
            e1 = {1'b1, req_we[g1], addr_of(g1), data_of(g1)};
        end
        check("ready", req_ready, er);
        check("port0", {CE0, WE0, A0, D0}, e0);
        check("port1", {CE1, WE1, A1, D1}, e1);
        check("rspv", rsp_valid, m_pv);
        for (int i = 0; i < NREQ; i++) begin
            if (m_pv[i]) check("rdata", rsp_rdata[i*DW +: DW], m_pd[i]);
            rdy_cnt[i] += int'(req_ready[i]);
        end
        @(posedge CLK);
        m_pv = '0;
        if (g0 >= 0 && !req_we[g0]) begin
            m_pv[g0] = 1'b1;
            m_pd[g0] = m_mem[addr_of(g0)];
        end
        if (g1 >= 0 && !req_we[g1]) begin
            m_pv[g1] = 1'b1;
            m_pd[g1] = m_mem[addr_of(g1)];
        end
        if (g0 >= 0 && req_we[g0]) m_mem[addr_of(g0)] = data_of(g0);
        if (g1 >= 0 && req_we[g1]) m_mem[addr_of(g1)] = data_of(g1);
        if (RST) m_ptr = 0;
        else if (g0 >= 0) m_ptr = ((g1 >= 0 ? g1 : g0) + 1) % NREQ;
        @(negedge CLK);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            bram[a]  = '0;
            m_mem[a] = '0;
        end
        m_ptr = 0;
        m_pv  = '0;
        for (int i = 0; i < NREQ; i++) begin
            m_pd[i]    = '0;
            rdy_cnt[i] = 0;
        end
        RST = 1'b1;
        clr();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 16 * i, 0);
        @(negedge CLK);
        tick();
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_ce", {CE0, CE1}, 0);

        // First cycle after release grants req0 and req1
        RST = 1'b0;
        #1;
        check("rel_ready", req_ready, 4'b0011);
        tick();

        // Write then read back through requester 2
        clr();
        set_req(2, 1, 1, 'h0A5, 9);
        tick();
        clr();
        set_req(2, 1, 0, 'h0A5, 0);
        tick();
        check("t2_v", rsp_valid, 4'b0100);
        check("t2_d", rsp_rdata[8 +: 4], 4'h9);
        clr();
        tick();

        // Fairness with every requester reading
        for (int i = 0; i < NREQ; i++) begin
            rdy_cnt[i] = 0;
            set_req(i, 1, 0, 100 + 3 * i, 0);
        end
        repeat (8) tick();
        for (int i = 0; i < NREQ; i++) check("fair", rdy_cnt[i], 4);

        // Write/read hazard on the same address
        clr();
        set_req(0, 1, 1, 'h123, 5);
        set_req(1, 1, 0, 'h123, 0);
        #1;
        check("t4_rdy", req_ready, 4'b0001);
        tick();
        clr();
        set_req(1, 1, 0, 'h123, 0);
        tick();
        check("t4_v", rsp_valid, 4'b0010);
        check("t4_d", rsp_rdata[4 +: 4], 4'h5);

        // Two reads of one address granted together
        clr();
        set_req(3, 1, 1, 'h7FF, 'hC);
        tick();
        clr();
        set_req(1, 1, 0, 'h7FF, 0);
        set_req(3, 1, 0, 'h7FF, 0);
        #1;
        check("t5_rdy", req_ready, 4'b1010);
        tick();
        check("t5_v", rsp_valid, 4'b1010);
        check("t5_d1", rsp_rdata[4 +: 4], 4'hC);
        check("t5_d3", rsp_rdata[12 +: 4], 4'hC);

        // Reset with a read in flight
        clr();
        set_req(0, 1, 0, 'h0A5, 0);
        tick();
        RST = 1'b1;
        #1;
        check("t6_rst", rsp_valid, 0);
        clr();
        tick();
        RST = 1'b0;
        tick();
        check("t6_post", rsp_valid, 0);
        tick();

        // Random traffic on a small address window to provoke hazards
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, ($urandom_range(0, 99) < 70),
                        ($urandom_range(0, 99) < 35),
                        $urandom_range(0, 7), $urandom_range(0, 15));
            end
            tick();
        end
        clr();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
